// File: rtl/xres_reset_conditioner.sv
// ----------------------------------------------------------------------------
// xres_reset_conditioner
//
// Conditions the buffered, asynchronous, active-low external reset pin into a
// clean, registered system reset for the clk domain.
//   1. A two-flop synchronizer brings xres_n_in into clk.
//   2. A consecutive-sample filter rejects short glitches. The filtered level
//      only changes after FILTER_CYCLES consecutive synchronized samples that
//      differ from it.
//   3. A three-state sequencer (ASSERT / HOLD / RUN) holds rst_out high for
//      HOLD_CYCLES cycles after the filtered level releases.
//   4. A saturating counter records how often a running system was pulled
//      back into reset by the external pin.
//
// Ports
//   clk           core clock; every register updates on its rising edge
//   reset         local synchronous reset, active-high; overrides everything
//   xres_n_in     external reset level from the pad buffer, active-low, async
//   rst_out       conditioned system reset, active-high, registered
//   rst_n_out     registered complement of rst_out
//   release_pulse one-cycle strobe on the first cycle rst_out reads 0
//   xres_filt     filtered, synchronized pin level (1 = released), debug
//   reset_count   saturating count of RUN->ASSERT transitions
// ----------------------------------------------------------------------------
module xres_reset_conditioner #(
   parameter int FILTER_CYCLES = 4,   // 1..255
   parameter int HOLD_CYCLES   = 16,  // 1..65535
   parameter int CNT_WIDTH     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 xres_n_in,
   output logic                 rst_out,
   output logic                 rst_n_out,
   output logic                 release_pulse,
   output logic                 xres_filt,
   output logic [CNT_WIDTH-1:0] reset_count
);

   localparam logic [1:0] ST_ASSERT = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;

   localparam logic [7:0]           FILT_LAST = 8'(FILTER_CYCLES - 1);
   localparam logic [15:0]          HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   // Synchronizer
   logic s1_reg;
   logic s2_reg;

   // Filter
   logic       filt_reg;
   logic       filt_next;
   logic [7:0] filt_cnt_reg;
   logic [7:0] filt_cnt_next;

   // Sequencer
   logic [1:0]           state_reg;
   logic [1:0]           state_next;
   logic [15:0]          hold_cnt_reg;
   logic [15:0]          hold_cnt_next;
   logic [CNT_WIDTH-1:0] reset_count_reg;
   logic [CNT_WIDTH-1:0] reset_count_next;

   // Registered outputs
   logic rst_out_reg;
   logic rst_out_next;
   logic rst_n_out_reg;
   logic release_pulse_reg;
   logic release_pulse_next;

   // ------------------------------------------------------------------------
   // Filter: any sample equal to the current level restarts the run, so only
   // an unbroken run of FILTER_CYCLES differing samples moves the level.
   // ------------------------------------------------------------------------
   always_comb begin
      filt_next     = filt_reg;
      filt_cnt_next = filt_cnt_reg;
      if (s2_reg == filt_reg) begin
         filt_cnt_next = 8'd0;
      end else if (filt_cnt_reg == FILT_LAST) begin
         filt_next     = s2_reg;
         filt_cnt_next = 8'd0;
      end else begin
         filt_cnt_next = filt_cnt_reg + 8'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer. In HOLD the pin check comes before the expiry check, so a pin
   // drop seen on the expiry edge aborts the release.
   // ------------------------------------------------------------------------
   always_comb begin
      state_next       = state_reg;
      hold_cnt_next    = hold_cnt_reg;
      reset_count_next = reset_count_reg;
      case (state_reg)
         ST_ASSERT: begin
            if (filt_reg) begin
               state_next    = ST_HOLD;
               hold_cnt_next = 16'd0;
            end
         end
         ST_HOLD: begin
            if (!filt_reg) begin
               state_next    = ST_ASSERT;
               hold_cnt_next = 16'd0;
            end else if (hold_cnt_reg == HOLD_LAST) begin
               state_next = ST_RUN;
            end else begin
               hold_cnt_next = hold_cnt_reg + 16'd1;
            end
         end
         ST_RUN: begin
            if (!filt_reg) begin
               state_next = ST_ASSERT;
               if (reset_count_reg != CNT_MAX) begin
                  reset_count_next = reset_count_reg + CNT_ONE;
               end
            end
         end
         default: begin
            state_next    = ST_ASSERT;
            hold_cnt_next = 16'd0;
         end
      endcase

      // Outputs are decoded from the next state so they change on the same
      // edge as the state register.
      rst_out_next       = (state_next != ST_RUN);
      release_pulse_next = (state_reg == ST_HOLD) && (state_next == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_reg            <= 1'b0;
         s2_reg            <= 1'b0;
         filt_reg          <= 1'b0;
         filt_cnt_reg      <= 8'd0;
         hold_cnt_reg      <= 16'd0;
         state_reg         <= ST_ASSERT;
         rst_out_reg       <= 1'b1;
         rst_n_out_reg     <= 1'b0;
         release_pulse_reg <= 1'b0;
         reset_count_reg   <= '0;
      end else begin
         s1_reg            <= xres_n_in;
         s2_reg            <= s1_reg;
         filt_reg          <= filt_next;
         filt_cnt_reg      <= filt_cnt_next;
         hold_cnt_reg      <= hold_cnt_next;
         state_reg         <= state_next;
         rst_out_reg       <= rst_out_next;
         rst_n_out_reg     <= !rst_out_next;
         release_pulse_reg <= release_pulse_next;
         reset_count_reg   <= reset_count_next;
      end
   end

   assign rst_out       = rst_out_reg;
   assign rst_n_out     = rst_n_out_reg;
   assign release_pulse = release_pulse_reg;
   assign xres_filt     = filt_reg;
   assign reset_count   = reset_count_reg;

endmodule

// File: tb/tb_xres_reset_conditioner.sv
// ----------------------------------------------------------------------------
// tb_xres_reset_conditioner
//
// Directed bench for xres_reset_conditioner with default parameters. Each step
// drives the pin or the local reset and pushes the outputs expected on chosen
// future cycles into a scoreboard queue. The queue entries are popped and
// compared when the cycle counter reaches their due cycle.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// that same point. An input driven while cyc == e is first sampled by edge
// e+1, so "N edges later" is due cycle e+N.
// ----------------------------------------------------------------------------
module tb_xres_reset_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic       xres_n_in;
   logic       rst_out;
   logic       rst_n_out;
   logic       release_pulse;
   logic       xres_filt;
   logic [7:0] reset_count;

   int cyc        = 0;
   int total_cnt  = 0;
   int pass_cnt   = 0;
   int fail_cnt   = 0;

   typedef struct {
      string      tag;
      int         due;
      logic       ro;
      logic       rn;
      logic       rp;
      logic       xf;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb_q[$];

   xres_reset_conditioner #(
      .FILTER_CYCLES(4),
      .HOLD_CYCLES  (16),
      .CNT_WIDTH    (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .xres_n_in    (xres_n_in),
      .rst_out      (rst_out),
      .rst_n_out    (rst_n_out),
      .release_pulse(release_pulse),
      .xres_filt    (xres_filt),
      .reset_count  (reset_count)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input string fld,
                      input logic [7:0] obs, input logic [7:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s.%s cyc=%0d: observed %0h expected %0h", tag, fld, cyc, obs, expv);
      end
   endtask

   task automatic expect_at(input string tag, input int due, input logic ro,
                            input logic rp, input logic xf, input logic [7:0] cnt);
      exp_t e;
      e.tag = tag;
      e.due = due;
      e.ro  = ro;
      e.rn  = !ro;
      e.rp  = rp;
      e.xf  = xf;
      e.cnt = cnt;
      sb_q.push_back(e);
   endtask

   // Advance n cycles; after each edge pop and compare every entry due now.
   task automatic run(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            cmp(e.tag, "due_cycle", 8'(cyc - e.due), 8'd0);
            cmp(e.tag, "rst_out", {7'd0, rst_out}, {7'd0, e.ro});
            cmp(e.tag, "rst_n_out", {7'd0, rst_n_out}, {7'd0, e.rn});
            cmp(e.tag, "release_pulse", {7'd0, release_pulse}, {7'd0, e.rp});
            cmp(e.tag, "xres_filt", {7'd0, xres_filt}, {7'd0, e.xf});
            cmp(e.tag, "reset_count", reset_count, e.cnt);
            $display("txn %-14s cyc=%0d rst_out=%0b rst_n_out=%0b release_pulse=%0b xres_filt=%0b reset_count=%0d",
                     e.tag, cyc, rst_out, rst_n_out, release_pulse, xres_filt, reset_count);
         end
      end
   endtask

   initial begin
      int e;
      int d;
      int r;
      logic [7:0] exp_cnt;

      // Power-up: 3 cycles of local reset with the pin released.
      reset     = 1'b1;
      xres_n_in = 1'b1;
      expect_at("rst_state", 1, 1'b1, 1'b0, 1'b0, 8'd0);
      expect_at("rst_state", 3, 1'b1, 1'b0, 1'b0, 8'd0);
      run(3);
      reset = 1'b0;
      e = cyc;
      expect_at("pwr_filt_pre", e + 5, 1'b1, 1'b0, 1'b0, 8'd0);
      expect_at("pwr_filt", e + 6, 1'b1, 1'b0, 1'b1, 8'd0);
      expect_at("pwr_hold_end", e + 22, 1'b1, 1'b0, 1'b1, 8'd0);
      expect_at("pwr_release", e + 23, 1'b0, 1'b1, 1'b1, 8'd0);
      expect_at("pwr_pulse_end", e + 24, 1'b0, 1'b0, 1'b1, 8'd0);
      run(26);

      // Assertion from RUN: pin held low.
      e = cyc;
      xres_n_in = 1'b0;
      expect_at("asrt_pre", e + 5, 1'b0, 1'b0, 1'b1, 8'd0);
      expect_at("asrt_filt", e + 6, 1'b0, 1'b0, 1'b0, 8'd0);
      expect_at("asrt_rst", e + 7, 1'b1, 1'b0, 1'b0, 8'd1);
      run(10);
      e = cyc;
      xres_n_in = 1'b1;
      expect_at("rel1_pre", e + 22, 1'b1, 1'b0, 1'b1, 8'd1);
      expect_at("rel1", e + 23, 1'b0, 1'b1, 1'b1, 8'd1);
      run(26);

      // Glitch of 3 cycles: rejected.
      e = cyc;
      xres_n_in = 1'b0;
      run(3);
      xres_n_in = 1'b1;
      expect_at("glitch3_a", e + 6, 1'b0, 1'b0, 1'b1, 8'd1);
      expect_at("glitch3_b", e + 10, 1'b0, 1'b0, 1'b1, 8'd1);
      run(10);

      // Pulse of 4 cycles: accepted, then auto-release.
      e = cyc;
      xres_n_in = 1'b0;
      run(4);
      xres_n_in = 1'b1;
      expect_at("pulse4_filt", e + 6, 1'b0, 1'b0, 1'b0, 8'd1);
      expect_at("pulse4_rst", e + 7, 1'b1, 1'b0, 1'b0, 8'd2);
      expect_at("pulse4_pre", e + 26, 1'b1, 1'b0, 1'b1, 8'd2);
      expect_at("pulse4_rel", e + 27, 1'b0, 1'b1, 1'b1, 8'd2);
      run(26);

      // Abort during HOLD with the filter falling on the hold-expiry edge.
      e = cyc;
      xres_n_in = 1'b0;
      expect_at("abort_asrt", e + 7, 1'b1, 1'b0, 1'b0, 8'd3);
      run(10);
      xres_n_in = 1'b1;
      run(16);
      d = cyc;
      xres_n_in = 1'b0;
      expect_at("abort_filt", d + 6, 1'b1, 1'b0, 1'b0, 8'd3);
      expect_at("abort_expiry", d + 7, 1'b1, 1'b0, 1'b0, 8'd3);
      expect_at("abort_after", d + 8, 1'b1, 1'b0, 1'b0, 8'd3);
      run(6);
      r = cyc;
      xres_n_in = 1'b1;
      expect_at("abort_hold22", r + 22, 1'b1, 1'b0, 1'b1, 8'd3);
      expect_at("abort_rel", r + 23, 1'b0, 1'b1, 1'b1, 8'd3);
      run(26);

      // Saturation: 254 further assert/release cycles (257 in total).
      for (int i = 0; i < 254; i++) begin
         exp_cnt = (4 + i > 255) ? 8'd255 : 8'(4 + i);
         e = cyc;
         xres_n_in = 1'b0;
         expect_at("sat_asrt", e + 7, 1'b1, 1'b0, 1'b0, exp_cnt);
         run(8);
         e = cyc;
         xres_n_in = 1'b1;
         expect_at("sat_rel", e + 23, 1'b0, 1'b1, 1'b1, exp_cnt);
         run(24);
      end

      // Local reset during HOLD.
      e = cyc;
      xres_n_in = 1'b0;
      expect_at("hold_asrt", e + 7, 1'b1, 1'b0, 1'b0, 8'd255);
      run(8);
      e = cyc;
      xres_n_in = 1'b1;
      expect_at("in_hold", e + 12, 1'b1, 1'b0, 1'b1, 8'd255);
      run(12);
      reset = 1'b1;
      expect_at("hold_lreset", cyc + 1, 1'b1, 1'b0, 1'b0, 8'd0);
      run(1);
      reset = 1'b0;
      e = cyc;
      expect_at("hold_lr_pre", e + 22, 1'b1, 1'b0, 1'b1, 8'd0);
      expect_at("hold_lr_rel", e + 23, 1'b0, 1'b1, 1'b1, 8'd0);
      run(24);

      // Local reset during RUN, asserted together with a pin drop.
      reset     = 1'b1;
      xres_n_in = 1'b0;
      expect_at("run_lreset", cyc + 1, 1'b1, 1'b0, 1'b0, 8'd0);
      run(1);
      reset     = 1'b0;
      xres_n_in = 1'b1;
      e = cyc;
      expect_at("run_lr_filt0", e + 5, 1'b1, 1'b0, 1'b0, 8'd0);
      expect_at("run_lr_filt1", e + 6, 1'b1, 1'b0, 1'b1, 8'd0);
      expect_at("run_lr_pre", e + 22, 1'b1, 1'b0, 1'b1, 8'd0);
      expect_at("run_lr_rel", e + 23, 1'b0, 1'b1, 1'b1, 8'd0);
      expect_at("run_lr_pend", e + 24, 1'b0, 1'b0, 1'b1, 8'd0);
      run(26);

      cmp("sb_drain", "entries_left", 8'(sb_q.size()), 8'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
